// File: rtl/regfile_debug_arbiter_if.sv
// Pipeline, debug-bridge and register-file signals seen by the register file debug arbiter.
// The arbiter uses the slave view; the surrounding SoC (or a bench) uses the master view.
interface regfile_debug_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              i_CpuWrEnable;
  logic [ADDR_W-1:0] i_CpuWrAddr;
  logic [DATA_W-1:0] i_CpuDataIn;
  logic [ADDR_W-1:0] i_CpuRdAddrA;
  logic [ADDR_W-1:0] i_CpuRdAddrB;
  logic              o_CpuStall;
  logic              i_DbgValid;
  logic              i_DbgWrite;
  logic [ADDR_W-1:0] i_DbgAddr;
  logic [DATA_W-1:0] i_DbgWrData;
  logic              o_DbgReady;
  logic              o_DbgRespValid;
  logic [DATA_W-1:0] o_DbgRdData;
  logic              o_RfWrEnable;
  logic [ADDR_W-1:0] o_RfWrAddr;
  logic [DATA_W-1:0] o_RfDataIn;
  logic [ADDR_W-1:0] o_RfRdAddrA;
  logic [ADDR_W-1:0] o_RfRdAddrB;
  logic [DATA_W-1:0] i_RfDataOutA;

  modport slave (
    input  i_CpuWrEnable, i_CpuWrAddr, i_CpuDataIn, i_CpuRdAddrA, i_CpuRdAddrB,
    input  i_DbgValid, i_DbgWrite, i_DbgAddr, i_DbgWrData, i_RfDataOutA,
    output o_CpuStall, o_DbgReady, o_DbgRespValid, o_DbgRdData,
    output o_RfWrEnable, o_RfWrAddr, o_RfDataIn, o_RfRdAddrA, o_RfRdAddrB
  );

  modport master (
    output i_CpuWrEnable, i_CpuWrAddr, i_CpuDataIn, i_CpuRdAddrA, i_CpuRdAddrB,
    output i_DbgValid, i_DbgWrite, i_DbgAddr, i_DbgWrData, i_RfDataOutA,
    input  o_CpuStall, o_DbgReady, o_DbgRespValid, o_DbgRdData,
    input  o_RfWrEnable, o_RfWrAddr, o_RfDataIn, o_RfRdAddrA, o_RfRdAddrB
  );
endinterface

// File: rtl/regfile_debug_arbiter.sv
// Shares the register file between the CPU pipeline and one debug requester; CPU writes always win.
// Debug read: response 3 cycles after accept; debug write: response 1 cycle after its free write slot.
module regfile_debug_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input logic                   i_Clk,
  input logic                   i_Rst,
  regfile_debug_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_CNT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    RD_ISSUE,
    RD_DATA,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              dbg_wr_slot;

  // The debug write only takes the port in a cycle the CPU leaves free.
  assign dbg_wr_slot = (state_q == WR_WAIT) && !bus.i_CpuWrEnable;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (bus.i_DbgValid) begin
          addr_d   = bus.i_DbgAddr;
          wdata_d  = bus.i_DbgWrData;
          rdata_d  = '0;
          starve_d = '0;
          state_d  = bus.i_DbgWrite ? WR_WAIT : RD_ISSUE;
        end
      end
      WR_WAIT: begin
        if (!bus.i_CpuWrEnable) begin
          state_d = RESP;
        end else if (starve_q != STARVE_CNT) begin
          starve_d = starve_q + 1'b1;
        end
      end
      RD_ISSUE: state_d = RD_DATA;
      RD_DATA: begin
        rdata_d = bus.i_RfDataOutA;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      starve_q <= starve_d;
    end
  end

  assign bus.o_DbgReady     = (state_q == IDLE);
  assign bus.o_DbgRespValid = (state_q == RESP);
  assign bus.o_DbgRdData    = rdata_q;
  assign bus.o_CpuStall     = (state_q == RD_ISSUE) || (state_q == RD_DATA) ||
                              ((state_q == WR_WAIT) && (starve_q == STARVE_CNT));

  assign bus.o_RfWrEnable = bus.i_CpuWrEnable | dbg_wr_slot;
  assign bus.o_RfWrAddr   = dbg_wr_slot ? addr_q : bus.i_CpuWrAddr;
  assign bus.o_RfDataIn   = dbg_wr_slot ? wdata_q : bus.i_CpuDataIn;
  assign bus.o_RfRdAddrA  = (state_q == RD_ISSUE) ? addr_q : bus.i_CpuRdAddrA;
  assign bus.o_RfRdAddrB  = bus.i_CpuRdAddrB;
endmodule
